img_row_axiw: RTL

- AXI4 write master that stores an incoming 128-bit pixel stream (4 x 32-bit pixels per beat) into the DDR frame buffer, row by row, as fixed-length INCR bursts.
- It is the write-side counterpart of the image read path: it fills the frame buffer that the resize/read logic later fetches from over AXI AR/R.
- Only one AXI transaction is outstanding at a time: AW, then W, then B.

---
 rtl/img_row_axiw_if.sv | 45 ++++
 rtl/img_row_axiw.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/img_row_axiw_if.sv
// ---------------------------------------------------------------------------
// img_row_axiw_if
// AXI4 write-channel bundle (AW, W, B) used by the img_row_axiw frame writer.
//   master : the writer (drives AW*/W* valid+payload and BREADY)
//   slave  : the interconnect / memory model (drives the READYs and B channel)
// ---------------------------------------------------------------------------
interface img_row_axiw_if;
    logic         AXI_AWREADY;
    logic         AXI_AWVALID;
    logic [31:0]  AXI_AWADDR;
    logic [7:0]   AXI_AWLEN;
    logic [3:0]   AXI_AWID;
    logic [2:0]   AXI_AWSIZE;
    logic [1:0]   AXI_AWBURST;
    logic [1:0]   AXI_AWLOCK;
    logic         AXI_WREADY;
    logic         AXI_WVALID;
    logic [127:0] AXI_WDATA;
    logic [15:0]  AXI_WSTRB;
    logic         AXI_WLAST;
    logic         AXI_BVALID;
    logic         AXI_BREADY;
    logic [3:0]   AXI_BID;
    logic [1:0]   AXI_BRESP;

    modport master (
        input  AXI_AWREADY,
        output AXI_AWVALID, AXI_AWADDR, AXI_AWLEN, AXI_AWID,
               AXI_AWSIZE, AXI_AWBURST, AXI_AWLOCK,
        input  AXI_WREADY,
        output AXI_WVALID, AXI_WDATA, AXI_WSTRB, AXI_WLAST,
        input  AXI_BVALID, AXI_BID, AXI_BRESP,
        output AXI_BREADY
    );

    modport slave (
        output AXI_AWREADY,
        input  AXI_AWVALID, AXI_AWADDR, AXI_AWLEN, AXI_AWID,
               AXI_AWSIZE, AXI_AWBURST, AXI_AWLOCK,
        output AXI_WREADY,
        input  AXI_WVALID, AXI_WDATA, AXI_WSTRB, AXI_WLAST,
        output AXI_BVALID, AXI_BID, AXI_BRESP,
        input  AXI_BREADY
    );
endinterface

// File: rtl/img_row_axiw.sv
// ---------------------------------------------------------------------------
// img_row_axiw
// AXI4 write master that stores a 128-bit pixel stream (4 x 32-bit pixels per
// beat, pixel 0 in [31:0]) into the DDR frame buffer as fixed-length INCR
// bursts, row by row. One transaction outstanding at a time: AW -> W -> B.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   i_frame_start   pulse that starts one frame write (ignored while busy)
//   i_pix_data      pixel beat, passed straight through to WDATA
//   i_pix_vld       stream valid (-> WVALID while in the W phase)
//   o_pix_ready     stream ready (= WREADY while in the W phase, else 0)
//   o_busy          frame write in progress
//   o_frame_done    one-cycle pulse after the last B response of a frame
//   o_bresp_err     sticky: a non-OKAY BRESP was seen since the last start
//   o_wr_buf_id     buffer currently being written
//   axi             AXI4 write channels (master modport)
//
// Optional feature (compile-time macro IMG_ROW_AXIW_PINGPONG_EN):
//   defined   -> frames alternate between BASE_ADDR and BASE_ADDR+FRAME_SIZE
//   undefined -> every frame goes to BASE_ADDR, o_wr_buf_id tied to 0
// ---------------------------------------------------------------------------
module img_row_axiw #(
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480,
    parameter int unsigned BURST_LEN  = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] FRAME_SIZE = 32'h0012_C000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_frame_start,
    input  logic [127:0]   i_pix_data,
    input  logic           i_pix_vld,
    output logic           o_pix_ready,
    output logic           o_busy,
    output logic           o_frame_done,
    output logic           o_bresp_err,
    output logic           o_wr_buf_id,
    img_row_axiw_if.master axi
);

    localparam int unsigned BEATS_ROW   = IMG_W / 4;
    localparam int unsigned BURSTS_ROW  = BEATS_ROW / BURST_LEN;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 16);
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [15:0] LAST_BIDX   = 16'(BURSTS_ROW - 1);
    localparam logic [15:0] LAST_ROW    = 16'(IMG_H - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

    state_t      r_state;
    logic [7:0]  r_beat;
    logic [15:0] r_bidx;
    logic [15:0] r_row;
    logic [31:0] r_addr;
    logic        r_awvalid;
    logic        r_bready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [31:0] w_base;
    logic        w_in_w;
    logic        w_wfire;
    logic        w_last_beat;
    logic        w_last_burst;
    logic        w_unused_bid;

`ifdef IMG_ROW_AXIW_PINGPONG_EN
    logic r_buf_id;
    assign w_base      = r_buf_id ? (BASE_ADDR + FRAME_SIZE) : BASE_ADDR;
    assign o_wr_buf_id = r_buf_id;
`else
    assign w_base      = BASE_ADDR;
    assign o_wr_buf_id = 1'b0;
`endif

    assign w_in_w       = (r_state == ST_W);
    assign w_wfire      = w_in_w && i_pix_vld && axi.AXI_WREADY;
    assign w_last_beat  = (r_beat == LAST_BEAT);
    assign w_last_burst = (r_bidx == LAST_BIDX) && (r_row == LAST_ROW);
    assign w_unused_bid = ^axi.AXI_BID;

    // Address channel and constant burst attributes.
    assign axi.AXI_AWVALID = r_awvalid;
    assign axi.AXI_AWADDR  = r_addr;
    assign axi.AXI_AWLEN   = LAST_BEAT;
    assign axi.AXI_AWID    = 4'h0;
    assign axi.AXI_AWSIZE  = 3'b100;
    assign axi.AXI_AWBURST = 2'b01;
    assign axi.AXI_AWLOCK  = 2'b00;

    // The W phase is a combinational pass-through so a beat costs no latency.
    assign axi.AXI_WVALID  = w_in_w && i_pix_vld;
    assign axi.AXI_WDATA   = i_pix_data;
    assign axi.AXI_WSTRB   = 16'hFFFF;
    assign axi.AXI_WLAST   = w_in_w && w_last_beat;
    assign o_pix_ready     = w_in_w && axi.AXI_WREADY;

    assign axi.AXI_BREADY  = r_bready;
    assign o_busy          = r_busy;
    assign o_frame_done    = r_done;
    assign o_bresp_err     = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_bidx    <= '0;
            r_row     <= '0;
            r_addr    <= '0;
            r_awvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef IMG_ROW_AXIW_PINGPONG_EN
            r_buf_id  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        r_row     <= '0;
                        r_bidx    <= '0;
                        r_beat    <= '0;
                        r_addr    <= w_base;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_state   <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (axi.AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_wfire) begin
                        if (w_last_beat) begin
                            r_beat   <= '0;
                            r_bready <= 1'b1;
                            r_state  <= ST_B;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                ST_B: begin
                    if (axi.AXI_BVALID) begin
                        r_bready <= 1'b0;
                        if (axi.AXI_BRESP != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        // Rows are contiguous (BURSTS_ROW*BURST_BYTES == row
                        // stride), so a single running address covers
                        // base + row*stride + bidx*burst_bytes.
                        r_addr <= r_addr + BURST_BYTES;
                        if (r_bidx == LAST_BIDX) begin
                            r_bidx <= '0;
                            r_row  <= r_row + 16'd1;
                        end else begin
                            r_bidx <= r_bidx + 16'd1;
                        end
                        if (w_last_burst) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
`ifdef IMG_ROW_AXIW_PINGPONG_EN
                            r_buf_id <= ~r_buf_id;
`endif
                        end else begin
                            r_awvalid <= 1'b1;
                            r_state   <= ST_AW;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
